cmp_result_debouncer: RTL

//  Consumes the one-hot L/E/G result of the upstream 2-bit magnitude comparator, sampled under in_valid.

---
 rtl/cmp_pkg.sv | 38 +++
 rtl/cmp_sat_counter.sv | 42 ++++
 rtl/cmp_result_debouncer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// +--------------------------------------------------------------------+
// | cmp_pkg                                                            |
// | Relation encodings and one-hot classifier for the L/E/G debouncer. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    REL_EQ  = 2'b00,
    REL_LT  = 2'b01,
    REL_GT  = 2'b10,
    REL_UNK = 2'b11
  } rel_e;

  typedef struct packed {
    logic legal;
    rel_e rel;
  } cls_t;

  // Anything other than exactly one of L/E/G high is illegal and maps to UNKNOWN.
  function automatic cls_t classify(input logic l, input logic e, input logic g);
    cls_t c;
    c.legal = 1'b1;
    c.rel   = REL_UNK;
    case ({l, e, g})
      3'b100:  c.rel = REL_LT;
      3'b010:  c.rel = REL_EQ;
      3'b001:  c.rel = REL_GT;
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_sat_counter.sv
// +--------------------------------------------------------------------+
// | cmp_sat_counter                                                    |
// | Saturating up-counter; synchronous clear has priority over inc.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module cmp_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cmp_result_debouncer.sv
// +--------------------------------------------------------------------+
// | cmp_result_debouncer                                               |
// | Commits an L/E/G relation after PERSIST identical valid samples.   |
// | Optional macro CMP_STICKY_ERR_EN: err_o sticky until clr/reset.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module cmp_result_debouncer
  import cmp_pkg::*;
#(
  parameter int PERSIST = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             L,
  input  logic             E,
  input  logic             G,
  input  logic             clr,
  output logic [1:0]       state_o,
  output logic             change_o,
  output logic [CNT_W-1:0] event_cnt,
  output logic             err_o
);

  localparam int RUN_W = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(PERSIST);

  rel_e             state_q, state_d;
  rel_e             cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             change_q, change_d;
  logic             err_q, err_d;

  cls_t             cls;
  logic [RUN_W-1:0] run_nxt;
  logic             illegal;
  logic             inc;

  always_comb begin
    cls      = classify(L, E, G);
    state_d  = state_q;
    cand_d   = cand_q;
    run_d    = run_q;
    run_nxt  = run_q;
    change_d = 1'b0;
    illegal  = 1'b0;
    inc      = 1'b0;

    if (in_valid) begin
      if (!cls.legal) begin
        illegal = 1'b1;
        run_d   = '0;
        cand_d  = REL_UNK;
      end else if (cls.rel == state_q) begin
        run_d  = '0;
        cand_d = REL_UNK;
      end else begin
        if (cls.rel == cand_q) begin
          run_nxt = run_q + 1'b1;
        end else begin
          cand_d  = cls.rel;
          run_nxt = RUN_W'(1);
        end

        // Leaving UNKNOWN is announced but not counted as a relation change.
        if (run_nxt == RUN_DONE) begin
          state_d  = cls.rel;
          change_d = 1'b1;
          run_d    = '0;
          cand_d   = REL_UNK;
          inc      = (state_q != REL_UNK);
        end else begin
          run_d = run_nxt;
        end
      end
    end

`ifdef CMP_STICKY_ERR_EN
    if (illegal) begin
      err_d = 1'b1;
    end else if (clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
`else
    err_d = illegal;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REL_UNK;
      cand_q   <= REL_UNK;
      run_q    <= '0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      run_q    <= run_d;
      change_q <= change_d;
      err_q    <= err_d;
    end
  end

  cmp_sat_counter #(
    .W (CNT_W)
  ) u_event_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .clr   (clr),
    .q     (event_cnt)
  );

  assign state_o  = state_q;
  assign change_o = change_q;
  assign err_o    = err_q;

endmodule

`default_nettype wire
